bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Sits directly upstream of the 4-bit BCD code converter. It supplies one packed 4-bit BCD digit per converter instance (p=MSB … s=LSB).
- Start/done handshake so a controller can launch a conversion and latch the result.

---
 rtl/bin2bcd_pkg.sv | 23 ++
 rtl/bin2bcd_seq_digit_adj.sv | 17 +
 rtl/bin2bcd_seq.sv | 109 ++++++++++
 tb/tb_bin2bcd_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Imported by the digit correction cell and the converter top.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] ADD3_TH  = 4'd5;
  localparam logic [3:0] ADD3_VAL = 4'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble correction cell: a digit of 5 or more gets +3.
// inv_o flags an incoming digit outside 0..9.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o,
  output logic       inv_o
);

  always_comb begin
    d_o   = d_i;
    inv_o = (d_i > 4'd9);
    if (d_i >= ADD3_TH) d_o = d_i + ADD3_VAL;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// start/done handshake; result and overflow held between done pulses.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = clog2(BIN_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIN_W - 1);

  state_e           state_q, state_d;
  logic [BIN_W-1:0] sh_q, sh_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    adj;
  logic [DIGITS-1:0] inv;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [AW-1:0]    bcd_q, bcd_d;
  logic             ovo_q, ovo_d;
  logic             done_q, done_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i   (acc_q[4*g +: 4]),
      .d_o   (adj[4*g +: 4]),
      .inv_o (inv[g])
    );
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    ovo_d   = ovo_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          sh_d    = bin_in;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_SHIFT;
        end
      end
      (state_q == S_SHIFT): begin
        {acc_d, sh_d} = {adj, sh_q} << 1;
        // a carry out of the top digit means the value needs more digits
        ovf_d = ovf_q | adj[AW-1] | (|inv);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      (state_q == S_DONE): begin
        bcd_d   = acc_q;
        ovo_d   = ovf_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      ovo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      ovo_q   <= ovo_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == S_SHIFT);
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovo_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: decimal-arithmetic model, per-cycle compare,
// directed vectors on a 3-digit and a 2-digit instance.
module tb_bin2bcd_seq;

  logic clk;
  logic rst_n;

  logic        start0, busy0, done0, ovf0;
  logic [7:0]  bin0;
  logic [11:0] bcd0;
  logic        start1, busy1, done1, ovf1;
  logic [7:0]  bin1;
  logic [7:0]  bcd1;

  int checks;
  int failures;
  int cyc;

  typedef struct {
    int v;
    int acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [11:0] last_b [2];
  logic        last_o [2];

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start0),
    .bin_in   (bin0),
    .busy     (busy0),
    .done     (done0),
    .bcd_out  (bcd0),
    .overflow (ovf0)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .bin_in   (bin1),
    .busy     (busy1),
    .done     (done1),
    .bcd_out  (bcd1),
    .overflow (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_bcd(input int v, input int digs);
    logic [11:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < digs; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check_out(input int i, input logic dn,
                           input logic [11:0] b, input logic ov);
    int   digs;
    int   lim;
    bit   have;
    exp_t e;
    digs = (i == 0) ? 3 : 2;
    lim  = (i == 0) ? 1000 : 100;
    if (dn) begin
      have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        chk($sformatf("unexpected_done%0d", i), 32'(dn), 32'd0);
      end else begin
        if (i == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("latency%0d", i), 32'(cyc), 32'(e.acc + 9));
        last_o[i] = (e.v >= lim);
        last_b[i] = model_bcd(e.v, digs);
      end
    end
    chk($sformatf("overflow%0d", i), 32'(ov), 32'(last_o[i]));
    if (!last_o[i]) begin
      chk($sformatf("bcd_out%0d", i), 32'(b), 32'(last_b[i]));
    end
    if (!ov) begin
      for (int k = 0; k < digs; k++) begin
        chk($sformatf("digit_range%0d", i), 32'(b[4*k +: 4] <= 4'd9), 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_out(0, done0, bcd0, ovf0);
      check_out(1, done1, {4'h0, bcd1}, ovf1);
    end
  end

  task automatic push(input int i, input int v);
    exp_t e;
    e.v   = v;
    e.acc = cyc + 1;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic set_in(input int i, input logic s, input logic [7:0] b);
    if (i == 0) begin
      start0 = s;
      bin0   = b;
    end else begin
      start1 = s;
      bin1   = b;
    end
  endtask

  // start one conversion, optionally poke start mid-SHIFT with bin=7
  task automatic run1(input int i, input int v, input bit inj,
                      output int nbusy);
    bit got;
    got   = 1'b0;
    nbusy = 0;
    @(negedge clk);
    set_in(i, 1'b1, 8'(v));
    push(i, v);
    @(negedge clk);
    set_in(i, 1'b0, 8'($urandom));
    nbusy += (i == 0) ? int'(busy0) : int'(busy1);
    for (int n = 0; n < 20 && !got; n++) begin
      if (inj && n == 2) set_in(i, 1'b1, 8'd7);
      if (inj && n == 3) set_in(i, 1'b0, 8'($urandom));
      @(negedge clk);
      if ((i == 0) ? done0 : done1) got = 1'b1;
      else nbusy += (i == 0) ? int'(busy0) : int'(busy1);
    end
    chk("done_timeout", 32'(got), 32'd1);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      last_b[i] = '0;
      last_o[i] = 1'b0;
    end
  endtask

  initial begin
    int nb;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    start0   = 1'b0;
    bin0     = '0;
    start1   = 1'b0;
    bin1     = '0;
    model_reset();
    #1;
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_done", 32'(done0), 32'd0);
    chk("reset_bcd", 32'(bcd0), 32'd0);
    chk("reset_ovf", 32'(ovf0), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run1(0, 0, 1'b0, nb);
    chk("busy_cycles", 32'(nb), 32'd8);
    chk("lit_000", 32'(bcd0), 32'h000);
    run1(0, 255, 1'b0, nb);
    chk("lit_255", 32'(bcd0), 32'h255);
    chk("lit_255_ovf", 32'(ovf0), 32'd0);
    run1(0, 99, 1'b0, nb);
    chk("lit_099", 32'(bcd0), 32'h099);
    run1(0, 100, 1'b0, nb);
    chk("lit_100", 32'(bcd0), 32'h100);
    run1(0, 42, 1'b1, nb);
    chk("lit_042", 32'(bcd0), 32'h042);
    repeat (15) @(negedge clk);
    chk("hold_042", 32'(bcd0), 32'h042);

    // asynchronous abort part-way through a conversion
    @(negedge clk);
    start0 = 1'b1;
    bin0   = 8'd200;
    push(0, 200);
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_bcd", 32'(bcd0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run1(0, 200, 1'b0, nb);
    chk("lit_200", 32'(bcd0), 32'h200);

    // start held high, operand stepping each conversion
    @(negedge clk);
    start0 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bin0 = 8'(k);
      push(0, k);
      repeat (10) @(negedge clk);
    end
    start0 = 1'b0;
    chk("stream_last", 32'(bcd0), 32'h015);
    repeat (5) @(negedge clk);
    chk("stream_drained", 32'(q0.size()), 32'd0);

    run1(1, 100, 1'b0, nb);
    chk("lit2_100_ovf", 32'(ovf1), 32'd1);
    run1(1, 99, 1'b0, nb);
    chk("lit2_99", 32'(bcd1), 32'h99);
    chk("lit2_99_ovf", 32'(ovf1), 32'd0);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
